// File: rtl/packet_injector_if.sv
// Flit bus between the packet injector and a router input port.
interface packet_injector_if;
    logic [17:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;

    modport master (
        output flit_out,
        output flit_valid,
        input  flit_ready
    );

    modport slave (
        input  flit_out,
        input  flit_valid,
        output flit_ready
    );
endinterface

// File: rtl/packet_injector.sv
// Turns a processor job word into a numbered sequence of flits on a valid/ready bus.
// Optional macro INJ_PARITY_EN: flit bit 8 carries even parity and the payload counter is 8 bits.
module packet_injector #(
    parameter logic [1:0] NODE_ID = 2'd0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [10:0]               configure,
    input  logic                      block,
    packet_injector_if.master         flit,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                sent_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [1:0]  dest_reg, dest_next;
    logic [7:0]  count_reg, count_next;
    logic [7:0]  sent_reg, sent_next;
    logic [17:0] flit_reg, flit_next;
    logic        valid_reg, valid_next;
    logic [7:0]  sent_inc;

    // Flit for the idx-th packet of the job; seq is the low five bits of idx.
    function automatic logic [17:0] build_flit(input logic [1:0] dest, input logic [7:0] idx);
        logic [17:0] f;
`ifdef INJ_PARITY_EN
        logic [7:0] payload;
        payload = idx + 8'd1;
        f = {dest, NODE_ID, idx[4:0], 1'b0, payload};
        f[8] = ^{f[17:9], f[7:0]};
`else
        logic [8:0] payload;
        payload = {1'b0, idx} + 9'd1;
        f = {dest, NODE_ID, idx[4:0], payload};
`endif
        return f;
    endfunction

    assign sent_inc = sent_reg + 8'd1;

    always_comb begin
        state_next = state_reg;
        dest_next  = dest_reg;
        count_next = count_reg;
        sent_next  = sent_reg;
        flit_next  = flit_reg;
        valid_next = valid_reg;
        case (state_reg)
            IDLE: begin
                if (configure[0]) begin
                    dest_next  = configure[2:1];
                    count_next = configure[10:3];
                    sent_next  = 8'd0;
                    if (configure[10:3] == 8'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SEND;
                        if (!block) begin
                            valid_next = 1'b1;
                            flit_next  = build_flit(configure[2:1], 8'd0);
                        end
                    end
                end
            end
            SEND: begin
                if (valid_reg && flit.flit_ready) begin
                    sent_next  = sent_inc;
                    valid_next = 1'b0;
                    flit_next  = 18'd0;
                    if (sent_inc == count_reg) begin
                        state_next = DONE;
                    end else if (!block) begin
                        valid_next = 1'b1;
                        flit_next  = build_flit(dest_reg, sent_inc);
                    end
                end else if (!valid_reg && !block) begin
                    // A flit held off by block is raised once block drops.
                    valid_next = 1'b1;
                    flit_next  = build_flit(dest_reg, sent_reg);
                end
            end
            DONE: begin
                if (!configure[0]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                flit_next  = 18'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            dest_reg  <= 2'd0;
            count_reg <= 8'd0;
            sent_reg  <= 8'd0;
            flit_reg  <= 18'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dest_reg  <= dest_next;
            count_reg <= count_next;
            sent_reg  <= sent_next;
            flit_reg  <= flit_next;
            valid_reg <= valid_next;
        end
    end

    assign flit.flit_out   = flit_reg;
    assign flit.flit_valid = valid_reg;
    assign busy            = (state_reg == SEND);
    assign done            = (state_reg == DONE);
    assign sent_count      = sent_reg;

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: a job table plus stall, block and mid-job reset sequences.
module tb_packet_injector;

    logic        clock = 1'b0;
    logic        reset;
    logic [10:0] configure;
    logic        block;
    logic        busy;
    logic        done;
    logic [7:0]  sent_count;

    packet_injector_if bus ();

    packet_injector #(.NODE_ID(2'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .configure  (configure),
        .block      (block),
        .flit       (bus),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int transfers = 0;

    always @(posedge clock) begin
        if (bus.flit_valid === 1'b1 && bus.flit_ready === 1'b1) transfers++;
    end

    typedef struct {
        logic [1:0] dest;
        logic [7:0] count;
    } job_t;

    job_t jobs [5];

    function automatic logic [17:0] exp_flit(input logic [1:0] d, input int i);
        logic [17:0] f;
        f = {d, 2'b00, 5'(i % 32), 9'(i + 1)};
`ifdef INJ_PARITY_EN
        f[8] = ^{f[17:9], f[7:0]};
`endif
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check_flit(input string name, input logic [1:0] d, input int i);
        chk({name, " valid"}, 32'(bus.flit_valid), 32'd1);
        chk({name, " flit"}, 32'(bus.flit_out), 32'(exp_flit(d, i)));
`ifdef INJ_PARITY_EN
        chk({name, " parity"}, 32'(^bus.flit_out), 32'd0);
`endif
    endtask

    task automatic hard_reset;
        reset = 1'b1;
        configure = 11'd0;
        block = 1'b0;
        bus.flit_ready = 1'b1;
        step;
        step;
        reset = 1'b0;
        transfers = 0;
    endtask

    initial begin
        jobs[0] = '{dest: 2'd3, count: 8'd2};
        jobs[1] = '{dest: 2'd0, count: 8'd1};
        jobs[2] = '{dest: 2'd1, count: 8'd0};
        jobs[3] = '{dest: 2'd2, count: 8'd40};
        jobs[4] = '{dest: 2'd1, count: 8'd255};

        reset = 1'b1;
        configure = 11'd0;
        block = 1'b0;
        bus.flit_ready = 1'b0;
        #12;
        chk("reset flit", 32'(bus.flit_out), 32'd0);
        chk("reset valid", 32'(bus.flit_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sent", 32'(sent_count), 32'd0);
        hard_reset;

        // Table of jobs with ready held high; configure is scrambled mid-job to show it is ignored.
        for (int j = 0; j < 5; j++) begin
            configure = {jobs[j].count, jobs[j].dest, 1'b1};
            transfers = 0;
            step;
            for (int i = 0; i < int'(jobs[j].count); i++) begin
                check_flit($sformatf("job%0d flit%0d", j, i), jobs[j].dest, i);
                if (i == 0) begin
                    chk($sformatf("job%0d busy", j), 32'(busy), 32'd1);
                    configure = {~jobs[j].count, ~jobs[j].dest, 1'b1};
                end
                step;
            end
            chk($sformatf("job%0d done", j), 32'(done), 32'd1);
            chk($sformatf("job%0d valid off", j), 32'(bus.flit_valid), 32'd0);
            chk($sformatf("job%0d sent", j), 32'(sent_count), 32'(jobs[j].count));
            chk($sformatf("job%0d transfers", j), 32'(transfers), 32'(jobs[j].count));
            step;
            chk($sformatf("job%0d done held", j), 32'(done), 32'd1);
            chk($sformatf("job%0d no restart", j), 32'(bus.flit_valid), 32'd0);
            configure = 11'd0;
            step;
            chk($sformatf("job%0d idle done", j), 32'(done), 32'd0);
            chk($sformatf("job%0d idle busy", j), 32'(busy), 32'd0);
        end

        // Back-pressure: ready low for three cycles after the first flit appears.
        hard_reset;
        configure = {8'd2, 2'd3, 1'b1};
        step;
        bus.flit_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            check_flit($sformatf("stall%0d", k), 2'd3, 0);
        end
        bus.flit_ready = 1'b1;
        step;
        check_flit("stall second", 2'd3, 1);
        step;
        chk("stall done", 32'(done), 32'd1);
        chk("stall transfers", 32'(transfers), 32'd2);
        chk("stall sent", 32'(sent_count), 32'd2);

        // Block raised before the first transfer edge: no new flit until it drops.
        hard_reset;
        configure = {8'd4, 2'd2, 1'b1};
        step;
        check_flit("blk first", 2'd2, 0);
        block = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("blk%0d valid", k), 32'(bus.flit_valid), 32'd0);
            chk($sformatf("blk%0d sent", k), 32'(sent_count), 32'd1);
        end
        block = 1'b0;
        step;
        check_flit("blk resume", 2'd2, 1);
        bus.flit_ready = 1'b0;
        block = 1'b1;
        step;
        step;
        check_flit("blk hold", 2'd2, 1);
        bus.flit_ready = 1'b1;
        block = 1'b0;
        step;
        check_flit("blk third", 2'd2, 2);
        step;
        check_flit("blk fourth", 2'd2, 3);
        step;
        chk("blk done", 32'(done), 32'd1);
        chk("blk transfers", 32'(transfers), 32'd4);

        // Asynchronous reset in the middle of a ten-flit job, start still high.
        hard_reset;
        configure = {8'd10, 2'd1, 1'b1};
        step;
        for (int k = 0; k < 5; k++) step;
        chk("mid sent", 32'(sent_count), 32'd5);
        check_flit("mid flit5", 2'd1, 5);
        #2;
        reset = 1'b1;
        #1;
        chk("async flit", 32'(bus.flit_out), 32'd0);
        chk("async valid", 32'(bus.flit_valid), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async sent", 32'(sent_count), 32'd0);
        #1;
        reset = 1'b0;
        step;
        check_flit("restart flit0", 2'd1, 0);
        chk("restart sent", 32'(sent_count), 32'd0);
        chk("restart busy", 32'(busy), 32'd1);
        hard_reset;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
